// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, digit type and digit-count helper
package bcd_pkg;

  localparam int c_BCD_NIBBLE_W = 4;

  typedef logic [c_BCD_NIBBLE_W-1:0] bcd_digit_t;

  // Decimal digits needed to hold 2^width - 1; valid for width 1..63.
  function automatic int f_min_digits(input int width);
    longint unsigned max_val;
    int digits;
    max_val = (64'd1 << width) - 64'd1;
    digits  = 1;
    for (int i = 0; i < 20; i++) begin
      if (max_val >= 64'd10) begin
        max_val = max_val / 64'd10;
        digits  = digits + 1;
      end
    end
    return digits;
  endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// rtl/bcd_add3_cell.sv - double-dabble correction: add 3 to a BCD digit >= 5
module bcd_add3_cell
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/hex_to_decimal.sv
// rtl/hex_to_decimal.sv - unrolled double-dabble binary-to-BCD with one output register
module hex_to_decimal
  import bcd_pkg::*;
#(
  parameter int g_Width  = 8,
  parameter int g_Digits = 3
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst,
  input  logic [g_Width-1:0]               i_Input_Hex,
  output logic [c_BCD_NIBBLE_W*g_Digits-1:0] o_Output_Dec,
  output logic                             o_Valid
);

  localparam int c_BCD_W = c_BCD_NIBBLE_W * g_Digits;

  if (g_Digits < f_min_digits(g_Width)) begin : g_param_check
    $error("hex_to_decimal: g_Digits=%0d too small for g_Width=%0d", g_Digits, g_Width);
  end

  logic [c_BCD_W-1:0] stage [0:g_Width];
  // Top bit shifted out of each stage; always zero when g_Digits is large enough.
  logic [g_Width-1:0] unused_msb;

  assign stage[0] = '0;

  for (genvar s = 0; s < g_Width; s++) begin : g_stage
    logic [c_BCD_W-1:0] adjusted;

    for (genvar d = 0; d < g_Digits; d++) begin : g_digit
      bcd_add3_cell u_cell (
        .digit    (stage[s][d*c_BCD_NIBBLE_W +: c_BCD_NIBBLE_W]),
        .adjusted (adjusted[d*c_BCD_NIBBLE_W +: c_BCD_NIBBLE_W])
      );
    end

    assign stage[s+1]    = {adjusted[c_BCD_W-2:0], i_Input_Hex[g_Width-1-s]};
    assign unused_msb[s] = adjusted[c_BCD_W-1];
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Output_Dec <= '0;
      o_Valid      <= 1'b0;
    end else begin
      o_Output_Dec <= stage[g_Width];
      o_Valid      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hex_to_decimal.sv
// tb/tb_hex_to_decimal.sv - directed and exhaustive checks of hex_to_decimal
module tb_hex_to_decimal;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_hex;
  logic [11:0] out_dec;
  logic        valid;

  int checks = 0;
  int errors = 0;

  hex_to_decimal #(.g_Width(8), .g_Digits(3)) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Input_Hex  (in_hex),
    .o_Output_Dec (out_dec),
    .o_Valid      (valid)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [7:0]  vec_in  [8];
  logic [11:0] vec_out [8];

  initial begin
    vec_in[0] = 8'd0;   vec_out[0] = 12'h000;
    vec_in[1] = 8'd255; vec_out[1] = 12'h255;
    vec_in[2] = 8'd9;   vec_out[2] = 12'h009;
    vec_in[3] = 8'd10;  vec_out[3] = 12'h010;
    vec_in[4] = 8'd99;  vec_out[4] = 12'h099;
    vec_in[5] = 8'd100; vec_out[5] = 12'h100;
    vec_in[6] = 8'd57;  vec_out[6] = 12'h057;
    vec_in[7] = 8'd199; vec_out[7] = 12'h199;

    rst    = 1'b1;
    in_hex = 8'd57;
    @(negedge clk);
    tick();
    tick();
    check("reset_dec", out_dec, 12'h000);
    check("reset_valid", {11'd0, valid}, 12'h000);

    rst = 1'b0;
    tick();
    check("post_reset_dec", out_dec, 12'h057);
    check("post_reset_valid", {11'd0, valid}, 12'h001);

    in_hex = 8'd57;
    tick();
    tick();
    check("nominal_57", out_dec, 12'h057);

    for (int i = 0; i < 8; i++) begin
      in_hex = vec_in[i];
      tick();
      check($sformatf("directed_%0d", vec_in[i]), out_dec, vec_out[i]);
    end

    in_hex = 8'd200;
    tick();
    check("b2b_200", out_dec, 12'h200);
    in_hex = 8'd201;
    #1;
    check("b2b_hold_before_edge", out_dec, 12'h200);
    tick();
    check("b2b_201", out_dec, 12'h201);
    in_hex = 8'd202;
    tick();
    check("b2b_202", out_dec, 12'h202);

    for (int v = 0; v < 256; v++) begin
      in_hex = 8'(v);
      if (v == 128) begin
        rst = 1'b1;
        tick();
        check("midstream_reset_dec", out_dec, 12'h000);
        check("midstream_reset_valid", {11'd0, valid}, 12'h000);
        rst = 1'b0;
      end
      tick();
      check($sformatf("sweep_%0d", v), out_dec, ref_bcd(v));
      check($sformatf("sweep_nibbles_%0d", v),
            {11'd0, (out_dec[3:0] <= 4'd9) && (out_dec[7:4] <= 4'd9) && (out_dec[11:8] <= 4'd9)},
            12'h001);
      check($sformatf("sweep_valid_%0d", v), {11'd0, valid}, 12'h001);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_to_decimal.md
Name: hex_to_decimal

Overview:
- Converts an unsigned binary value (shown in hex) into packed BCD, one 4-bit nibble per decimal digit.
- Feeds display/readout logic, e.g. seven-segment drivers, that needs decimal digits.
- Conversion is a combinational double-dabble (shift-add-3) network followed by a single output register.
- Fully pipelined: a new input is accepted every clock.

Parameters:
- g_Width, 8, bit width of the binary input.
- g_Digits, 3, number of BCD digits on the output. Must satisfy 10^g_Digits > 2^g_Width - 1. Default 3 covers 0..255.

Ports:
- i_Clk  input  1  system clock (100 MHz nominal), all state on rising edge.
- i_Rst  input  1  reset, synchronous, active-high.
- i_Input_Hex  input  g_Width (8)  unsigned binary value to convert.
- o_Output_Dec  output  4*g_Digits (12)  packed BCD result.
  - [3:0] ones, [7:4] tens, [11:8] hundreds.
- o_Valid  output  1  high when o_Output_Dec holds a converted value, i.e. not in the cycle after reset.

Behaviour:
- Reset (i_Rst high at a rising edge):
  - o_Output_Dec <= 0, o_Valid <= 0.
  - Reset takes priority over the conversion update on the same edge.
  - Asserting reset mid-stream discards the in-flight result.
- Latency: exactly 1 clock.
  - On each rising edge with i_Rst low: o_Output_Dec <= BCD(i_Input_Hex) and o_Valid <= 1.
  - An input applied before edge N appears after edge N.
  - Any value settled before 2 rising edges is therefore guaranteed visible.
- No handshake. Input is sampled every cycle; the output follows the input with 1-cycle delay and changes on every input change.
- Conversion algorithm (double-dabble), iterated g_Width times, MSB first:
  - Before each shift, every BCD nibble >= 5 gets +3.
  - Then the nibbles and the remaining input bits are shifted left by one.
  - Implemented as unrolled combinational logic; no iterative FSM.
- Arithmetic:
  - Input is unsigned.
  - Every output nibble is always 0..9.
  - Unused high digits are 0. For example, 9 gives 0x009.
- Boundaries:
  - 0 -> 0x000.
  - 2^g_Width - 1 (255) -> 0x255.
  - Digit rollover: 99 -> 0x099, 100 -> 0x100.
- Parameter check: elaboration fails (assertion/$error) if g_Digits is too small for g_Width.
- No X propagation from reset state. The output register is always reset to a defined value.

Decomposition:
- Shared package bcd_pkg:
  - Constant c_BCD_NIBBLE_W = 4.
  - Function f_min_digits(width), used in the parameter check.
  - Typedef for a BCD digit, logic [3:0].
- One natural sub-module: bcd_add3_cell.
  - 4-bit in/out: output = input + 3 when input >= 5, else input unchanged.
  - Instantiated in a generate array across shift stages and digits.
- The top level holds the generate network plus the output register.

Test Plan:
- Reset: hold i_Rst high for 2 clocks with input 57 -> o_Output_Dec = 0x000 and o_Valid = 0. Release reset -> 0x057 (decimal 87) and o_Valid = 1 one clock later.
- Nominal: i_Input_Hex = 57 (0x39), check after 2 edges -> o_Output_Dec = 0x057 (decimal 87).
- Boundaries:
  - 0 -> 0x000.
  - 255 (0xFF) -> 0x255.
  - 9 -> 0x009.
  - 10 -> 0x010.
  - 99 -> 0x099.
  - 100 -> 0x100.
- Back-to-back: change input every clock through 200, 201, 202 -> outputs 0x200, 0x201, 0x202 on consecutive cycles, each exactly 1 clock after its input.
- Exhaustive: sweep 0..255 against a reference model using integer divide/modulo. Every nibble must be <= 9 and the result must match.
- Reset mid-stream: assert i_Rst during the sweep -> output 0x000 and o_Valid = 0 on the next edge. After release, correct conversion resumes with 1-cycle latency.
